// File: rtl/pe2_ctrl_pkg.sv
// Shared types and mode helpers for the PE2 add/sub butterfly job sequencer.
package pe2_ctrl_pkg;

  typedef enum logic [1:0] {
    K_NTT  = 2'b00,
    K_INTT = 2'b01,
    D_NTT  = 2'b10,
    D_INTT = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Returns {sel_0, sel_1, KD_mode} for the given transform mode.
  function automatic logic [2:0] mode_ctrl(mode_t m);
    case (m)
      K_NTT:   return 3'b100;
      K_INTT:  return 3'b010;
      D_NTT:   return 3'b001;
      default: return 3'b011;
    endcase
  endfunction

  function automatic int mode_lat(mode_t m, int mem_lat, int lat_base,
                                  int lat_half, int lat_shift);
    int l;
    l = mem_lat + lat_base;
    if (m == K_INTT || m == D_INTT) l = l + lat_half;
    if (m == D_INTT) l = l + lat_shift;
    return l;
  endfunction

endpackage

// File: rtl/pe2_vld_pipe.sv
// {valid, idx} delay line mirroring PE2's fixed latency, with a runtime-selected
// output tap and an indicator of any valid entry still upstream of that tap.
module pe2_vld_pipe #(
  parameter int DEPTH = 9,
  parameter int IDX_W = 8,
  parameter int TAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [TAP_W-1:0] tap,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             upstream
);

  logic [DEPTH-1:0] vld_p;
  logic [IDX_W-1:0] idx_p [DEPTH];

  // clr drops leftovers of a previous job that sit beyond that job's tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) idx_p[i] <= '0;
    end else begin
      vld_p[0] <= in_vld;
      idx_p[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1] & ~clr;
        idx_p[i] <= idx_p[i-1];
      end
    end
  end

  assign out_vld = vld_p[tap];
  assign out_idx = idx_p[tap];

  always_comb begin
    upstream = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (TAP_W'(i) < tap) upstream = upstream | vld_p[i];
    end
  end

endmodule

// File: rtl/pe2_ctrl.sv
// PE2 butterfly job sequencer: issues operand reads and aligns write strobes
// to the mode-dependent PE2 latency. Define PE2_CTRL_STALL_EN to honour stall.
module pe2_ctrl
  import pe2_ctrl_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MEM_LAT   = 1,
  parameter int LAT_BASE  = 1,
  parameter int LAT_HALF  = 1,
  parameter int LAT_SHIFT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             stall,
  output logic             sel_0,
  output logic             sel_1,
  output logic             KD_mode,
  output logic             rd_en,
  output logic [CNT_W-1:0] rd_idx,
  output logic             wr_en,
  output logic [CNT_W-1:0] wr_idx,
  output logic             busy,
  output logic             done
);

  localparam int LAT_MAX = MEM_LAT + LAT_BASE + LAT_HALF + LAT_SHIFT;
  localparam int TAP_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_t           state;
  mode_t            mode;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             issue;
  logic [TAP_W-1:0] tap;
  logic             upstream;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

`ifdef PE2_CTRL_STALL_EN
  assign issue = (state == ST_RUN) & ~stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign issue = (state == ST_RUN);
`endif

  assign tap = TAP_W'(mode_lat(mode, MEM_LAT, LAT_BASE, LAT_HALF, LAT_SHIFT) - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode    <= K_NTT;
      len     <= '0;
      cnt     <= '0;
      sel_0   <= 1'b0;
      sel_1   <= 1'b0;
      KD_mode <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state <= ST_RUN;
            mode  <= mode_t'(cmd_mode);
            len   <= cmd_len;
            cnt   <= '0;
            {sel_0, sel_1, KD_mode} <= mode_ctrl(mode_t'(cmd_mode));
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (cnt == len) state <= ST_DRAIN;
            else            cnt   <= cnt + CNT_W'(1);
          end
        end
        // Leave once nothing remains before the tap; the tap entry (if any)
        // is the final write, so done lands on the following cycle.
        ST_DRAIN: begin
          if (!upstream) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          {sel_0, sel_1, KD_mode} <= 3'b000;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pe2_vld_pipe #(
    .DEPTH (LAT_MAX),
    .IDX_W (CNT_W),
    .TAP_W (TAP_W)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .in_vld   (issue),
    .in_idx   (cnt),
    .tap      (tap),
    .out_vld  (wr_en),
    .out_idx  (wr_idx),
    .upstream (upstream)
  );

  assign rd_en  = issue;
  assign rd_idx = issue ? cnt : '0;
  assign busy   = ~cmd_ready;
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_pe2_ctrl.sv
// Directed, table-driven bench for pe2_ctrl (stall expectations follow PE2_CTRL_STALL_EN).
module tb_pe2_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [7:0] cmd_len = 8'd0;
  logic       stall = 1'b0;
  logic       sel_0, sel_1, KD_mode;
  logic       rd_en, wr_en, busy, done;
  logic [7:0] rd_idx, wr_idx;

  int total  = 0;
  int passed = 0;
  int rdc [0:63];

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] len;
    int         lat;
    logic       s0, s1, kd;
  } vec_t;

  vec_t tbl [6];

  pe2_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_len   (cmd_len),
    .stall     (stall),
    .sel_0     (sel_0),
    .sel_1     (sel_1),
    .KD_mode   (KD_mode),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required $finish before 200000");
    $fatal(1, "timeout");
  end

  // {cmd_ready, busy, done, rd_en, rd_idx, wr_en, wr_idx, sel_0, sel_1, KD_mode}
  function automatic logic [23:0] pack(logic r, logic b, logic d, logic re, logic [7:0] ri,
                                       logic we, logic [7:0] wi, logic s0, logic s1, logic kd);
    return {r, b, d, re, ri, we, wi, s0, s1, kd};
  endfunction

  function automatic logic [23:0] obs();
    return pack(cmd_ready, busy, done, rd_en, rd_en ? rd_idx : 8'd0,
                wr_en, wr_en ? wr_idx : 8'd0, sel_0, sel_1, KD_mode);
  endfunction

  task automatic check(input string nm, input int k, input logic [23:0] exp);
    logic [23:0] o;
    o = obs();
    total++;
    if (o !== exp)
      $display("FAIL %s cycle %0d: got %h required %h (rdy,busy,done,rd_en,rd_idx,wr_en,wr_idx,s0,s1,kd)",
               nm, k, o, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts a command in the current cycle and checks every cycle until
  // cmd_ready returns. rdc[] holds the expected issue cycle of each index.
  task automatic run_job(input string nm, input logic [1:0] m, input logic [7:0] len,
                         input int lat, input logic s0, input logic s1, input logic kd,
                         input int slo, input int shi, input bit hold,
                         input logic [1:0] hm, input logic [7:0] hl);
    int n, dn;
    logic re, we;
    logic [7:0] ri, wi;
    n = int'(len) + 1;
    dn = rdc[n-1] + lat + 1;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = len;
    stall     = 1'b0;
    #1;
    check({nm, "_accept"}, 0, pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= dn + 1; k++) begin
      @(posedge clk);
      #1;
      if (hold) begin
        cmd_mode = hm;
        cmd_len  = hl;
      end else begin
        cmd_valid = 1'b0;
      end
      stall = (k >= slo && k <= shi);
      #1;
      re = 1'b0; ri = 8'd0; we = 1'b0; wi = 8'd0;
      for (int i = 0; i < n; i++) begin
        if (k == rdc[i])       begin re = 1'b1; ri = 8'(i); end
        if (k == rdc[i] + lat) begin we = 1'b1; wi = 8'(i); end
      end
      if (k <= dn)
        check(nm, k, pack(1'b0, 1'b1, k == dn, re, ri, we, wi, s0, s1, kd));
      else
        check(nm, k, pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    end
    stall = 1'b0;
  endtask

  initial begin
    tbl[0] = '{"k_ntt_len3",  2'b00, 8'd3, 2, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"d_intt_len0", 2'b11, 8'd0, 9, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{"k_intt_len4", 2'b01, 8'd4, 3, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{"d_ntt_len5",  2'b10, 8'd5, 2, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{"k_ntt_len2",  2'b00, 8'd2, 2, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{"d_intt_len2", 2'b11, 8'd2, 9, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    step();

    // Back-to-back unstalled jobs, each starting the cycle cmd_ready returns
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i <= int'(tbl[t].len); i++) rdc[i] = 1 + i;
      run_job(tbl[t].name, tbl[t].mode, tbl[t].len, tbl[t].lat,
              tbl[t].s0, tbl[t].s1, tbl[t].kd, -1, -1, 1'b0, 2'b00, 8'd0);
    end
    step();

    // cmd_valid held through a D_NTT job with a different command behind it
    for (int i = 0; i < 4; i++) rdc[i] = 1 + i;
    run_job("hold_d_ntt", 2'b10, 8'd3, 2, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1, 2'b01, 8'd1);
    for (int i = 0; i < 2; i++) rdc[i] = 1 + i;
    run_job("held_k_intt", 2'b01, 8'd1, 3, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0, 2'b00, 8'd0);
    step();

    // K_INTT len=4 with stall high during cycles 2-3
`ifdef PE2_CTRL_STALL_EN
    rdc[0] = 1; rdc[1] = 4; rdc[2] = 5; rdc[3] = 6; rdc[4] = 7;
`else
    rdc[0] = 1; rdc[1] = 2; rdc[2] = 3; rdc[3] = 4; rdc[4] = 5;
`endif
    run_job("stall_k_intt", 2'b01, 8'd4, 3, 1'b0, 1'b1, 1'b0, 2, 3, 1'b0, 2'b00, 8'd0);
    step();

    // Asynchronous reset during DRAIN of a D_INTT job aborts it
    cmd_valid = 1'b1;
    cmd_mode  = 2'b11;
    cmd_len   = 8'd1;
    step();
    cmd_valid = 1'b0;
    #1;
    check("abort_issue0", 1, pack(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    repeat (4) step();
    check("abort_drain", 5, pack(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1));
    rst = 1'b1;
    #1;
    check("abort_rst_async", 5, pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    step();
    rst = 1'b0;
    for (int k = 7; k <= 18; k++) begin
      step();
      check("abort_quiet", k, pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
